// File: rtl/int_to_dlfloat16_pipe.sv
// Multi-lane two-stage integer to DLFloat16 (1/6/9, bias 31) converter with
// valid/ready flow control, RNE/RTZ rounding, saturation and per-lane flags.
module int_to_dlfloat16_pipe #(
    parameter int         INT_WIDTH = 32,
    parameter int         LANES     = 2,
    parameter logic [3:0] ENA_CODE  = 4'b0111
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [3:0]                   ena,
    input  logic                         signed_mode,
    input  logic                         rnd_mode,
    input  logic [LANES*INT_WIDTH-1:0]   in_int,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*16-1:0]          float_out,
    output logic [LANES*5-1:0]           exceptions
);

    localparam int PW = (INT_WIDTH > 1) ? $clog2(INT_WIDTH) : 1;
    localparam int FW = INT_WIDTH + 10;

    logic                                s1_valid_q, s1_valid_d;
    logic                                s1_conv_q, s1_conv_d;
    logic                                s1_rtz_q, s1_rtz_d;
    logic [LANES-1:0]                    s1_sign_q, s1_sign_d;
    logic [LANES-1:0][INT_WIDTH-1:0]     s1_mag_q, s1_mag_d;
    logic [LANES-1:0][PW-1:0]            s1_pos_q, s1_pos_d;
    logic                                out_valid_q, out_valid_d;
    logic [LANES*16-1:0]                 float_q, float_d;
    logic [LANES*5-1:0]                  exc_q, exc_d;
    logic                                s2_free;

    function automatic logic [INT_WIDTH:0] split_sign(input logic [INT_WIDTH-1:0] x,
                                                      input logic sm);
        logic neg;
        neg = sm && x[INT_WIDTH-1];
        return {neg, neg ? -x : x};
    endfunction

    function automatic logic [PW-1:0] lead_one(input logic [INT_WIDTH-1:0] m);
        logic [PW-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < INT_WIDTH; i++) begin
            if (m[i]) p = PW'(i);
        end
        return p;
    endfunction

    // Returns {flags[4:0], float[15:0]} for one lane.
    function automatic logic [20:0] pack_lane(input logic                 sign,
                                              input logic [INT_WIDTH-1:0] mag,
                                              input logic [PW-1:0]        pos,
                                              input logic                 rtz);
        logic [FW-1:0] frac;
        logic [8:0]    mant;
        logic          g, s, inc;
        logic [9:0]    mant_r;
        logic [7:0]    bexp;
        logic [15:0]   f;
        logic [4:0]    fl;
        // Left-justify so the leading one falls off the top; what remains is mantissa, G, sticky.
        frac   = FW'({mag, 11'b0} << (8'(INT_WIDTH - 1) - 8'(pos)));
        mant   = frac[FW-1 -: 9];
        g      = frac[FW-10];
        s      = |frac[FW-11:0];
        inc    = !rtz && g && (s || mant[0]);
        mant_r = {1'b0, mant} + {9'd0, inc};
        bexp   = 8'(pos) + 8'd31 + {7'd0, mant_r[9]};
        f      = {sign, bexp[5:0], mant_r[8:0]};
        fl     = {1'b0, g | s, 3'b000};
        if (bexp > 8'd63 || (bexp == 8'd63 && mant_r[8:0] == 9'd511)) begin
            f  = {sign, 6'd63, 9'd510};
            fl = 5'b01100;
        end
        if (mag == '0) begin
            f  = '0;
            fl = '0;
        end
        return {fl, f};
    endfunction

    assign s2_free  = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_free;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_conv_d  = s1_conv_q;
        s1_rtz_d   = s1_rtz_q;
        s1_sign_d  = s1_sign_q;
        s1_mag_d   = s1_mag_q;
        s1_pos_d   = s1_pos_q;
        if (in_ready) s1_valid_d = in_valid;
        if (in_valid && in_ready) begin
            s1_conv_d = (ena == ENA_CODE);
            s1_rtz_d  = rnd_mode;
            for (int unsigned k = 0; k < LANES; k++) begin
                {s1_sign_d[k], s1_mag_d[k]} = split_sign(in_int[k*INT_WIDTH +: INT_WIDTH],
                                                         signed_mode);
                s1_pos_d[k] = lead_one(s1_mag_d[k]);
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        float_d     = float_q;
        exc_d       = exc_q;
        if (s2_free) out_valid_d = s1_valid_q;
        if (s2_free && s1_valid_q) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (s1_conv_q) begin
                    {exc_d[k*5 +: 5], float_d[k*16 +: 16]} =
                        pack_lane(s1_sign_q[k], s1_mag_q[k], s1_pos_q[k], s1_rtz_q);
                end else begin
                    exc_d[k*5 +: 5]     = '0;
                    float_d[k*16 +: 16] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_conv_q   <= 1'b0;
            s1_rtz_q    <= 1'b0;
            s1_sign_q   <= '0;
            s1_mag_q    <= '0;
            s1_pos_q    <= '0;
            out_valid_q <= 1'b0;
            float_q     <= '0;
            exc_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_conv_q   <= s1_conv_d;
            s1_rtz_q    <= s1_rtz_d;
            s1_sign_q   <= s1_sign_d;
            s1_mag_q    <= s1_mag_d;
            s1_pos_q    <= s1_pos_d;
            out_valid_q <= out_valid_d;
            float_q     <= float_d;
            exc_q       <= exc_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign float_out  = float_q;
    assign exceptions = exc_q;

endmodule

// File: tb/tb_int_to_dlfloat16_pipe.sv
// Scoreboard bench for int_to_dlfloat16_pipe: 32-bit/2-lane main instance
// plus a 64-bit single-lane instance for the saturation corner cases.
module tb_int_to_dlfloat16_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, signed_mode, rnd_mode, out_valid, out_ready;
    logic [3:0]  ena;
    logic [63:0] in_int;
    logic [31:0] float_out;
    logic [9:0]  exceptions;

    logic        w_in_valid, w_in_ready, w_sm, w_rnd, w_out_valid, w_out_ready;
    logic [3:0]  w_ena;
    logic [63:0] w_in;
    logic [15:0] w_float;
    logic [4:0]  w_exc;

    int total = 0;
    int bad = 0;
    int stalls_seen = 0;
    int rdy_mode = 0;
    int bp_idx = 0;
    logic [41:0] sb[$];

    logic        prev_stall = 1'b0;
    logic [31:0] prev_f;
    logic [9:0]  prev_e;

    int_to_dlfloat16_pipe #(.INT_WIDTH(32), .LANES(2), .ENA_CODE(4'b0111)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ena(ena),
        .signed_mode(signed_mode), .rnd_mode(rnd_mode), .in_int(in_int),
        .out_valid(out_valid), .out_ready(out_ready), .float_out(float_out),
        .exceptions(exceptions)
    );

    int_to_dlfloat16_pipe #(.INT_WIDTH(64), .LANES(1), .ENA_CODE(4'b0111)) dut64 (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .ena(w_ena),
        .signed_mode(w_sm), .rnd_mode(w_rnd), .in_int(w_in),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .float_out(w_float),
        .exceptions(w_exc)
    );

    always #5 clk = ~clk;

    // out_ready pattern: 0 = always ready, 1 = never ready, 2 = 1,0,0,1 repeating
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = 1'b0;
        else out_ready = (bp_idx % 4 == 0) || (bp_idx % 4 == 3);
        bp_idx++;
    end

    always @(negedge clk) begin
        logic [41:0] expv;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                total++;
                if (out_valid !== 1'b1 || float_out !== prev_f || exceptions !== prev_e) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%b f=%h e=%h want v=1 f=%h e=%h",
                             out_valid, float_out, exceptions, prev_f, prev_e);
                end
            end
            if (in_ready !== 1'b1) begin
                stalls_seen++;
                total++;
                if (!(out_valid === 1'b1 && out_ready === 1'b0)) begin
                    bad++;
                    $display("FAIL in_ready_low: got out_valid=%b out_ready=%b want 1 0",
                             out_valid, out_ready);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output: got f=%h e=%h want no output",
                             float_out, exceptions);
                end else begin
                    expv = sb.pop_front();
                    if ({exceptions, float_out} !== expv) begin
                        bad++;
                        $display("FAIL result: got e=%h f=%h want e=%h f=%h",
                                 exceptions, float_out, expv[41:32], expv[31:0]);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_f = float_out;
            prev_e = exceptions;
        end
    end

    // Reference conversion built on quotient/remainder rounding; returns {flags, float}.
    function automatic logic [20:0] ref_conv(input logic [63:0] x, input int w,
                                             input logic sm, input logic rtz);
        logic [63:0] mask, mag, trunc, rem, half;
        logic        neg, up, inexact;
        logic [8:0]  mant;
        int          p, e;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        neg  = sm && x[w-1];
        mag  = neg ? ((~x + 64'd1) & mask) : (x & mask);
        if (mag == 64'd0) return '0;
        p = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) p = i;
        if (p >= 9) begin
            trunc = mag >> (p - 9);
            rem   = mag - (trunc << (p - 9));
        end else begin
            trunc = mag << (9 - p);
            rem   = 64'd0;
        end
        half    = (p >= 10) ? (64'd1 << (p - 10)) : 64'd0;
        inexact = (rem != 64'd0);
        up      = !rtz && (p >= 10) && ((rem > half) || (rem == half && trunc[0]));
        trunc   = trunc + 64'(up);
        e       = p + 31;
        if (trunc == 64'd1024) begin
            trunc = 64'd512;
            e++;
        end
        mant = trunc[8:0];
        if (e > 63 || (e == 63 && mant == 9'd511)) return {5'b01100, neg, 6'd63, 9'd510};
        return {1'b0, inexact, 3'b000, neg, e[5:0], mant};
    endfunction

    function automatic logic [41:0] exp2(input logic [31:0] a0, input logic [31:0] a1,
                                         input logic [3:0] e, input logic sm, input logic rtz);
        logic [20:0] r0, r1;
        if (e != 4'b0111) return '0;
        r0 = ref_conv({32'd0, a0}, 32, sm, rtz);
        r1 = ref_conv({32'd0, a1}, 32, sm, rtz);
        return {r1[20:16], r0[20:16], r1[15:0], r0[15:0]};
    endfunction

    function automatic logic [31:0] rnd_val();
        logic [31:0] v;
        v = $urandom;
        return v >> $urandom_range(0, 31);
    endfunction

    task automatic send(input logic [31:0] a0, input logic [31:0] a1, input logic [3:0] e,
                        input logic sm, input logic rtz, input logic [41:0] expv);
        logic acc;
        in_valid = 1'b1;
        in_int = {a1, a0};
        ena = e;
        signed_mode = sm;
        rnd_mode = rtz;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                sb.push_back(expv);
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL send_timeout: got in_ready=0 for 50 cycles want acceptance");
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total += 5;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (float_out !== 32'h0) begin bad++; $display("FAIL reset_float: got %h want 0", float_out); end
        if (exceptions !== 10'h0) begin bad++; $display("FAIL reset_exc: got %h want 0", exceptions); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        if (w_out_valid !== 1'b0) begin bad++; $display("FAIL reset_w_out_valid: got %b want 0", w_out_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_values();
        rdy_mode = 0;
        send(32'd1, 32'hFFFFFFFF, 4'b0111, 1'b1, 1'b0, {5'h00, 5'h00, 16'hBE00, 16'h3E00});
        send(32'd1000, 32'd0, 4'b0111, 1'b1, 1'b0, {5'h00, 5'h00, 16'h0000, 16'h51E8});
        send(32'd1025, 32'd1027, 4'b0111, 1'b1, 1'b0, {5'h08, 5'h08, 16'h5202, 16'h5200});
        send(32'd1027, 32'd2047, 4'b0111, 1'b1, 1'b1, {5'h08, 5'h08, 16'h53FF, 16'h5201});
        send(32'd2047, 32'h80000000, 4'b0111, 1'b1, 1'b0, {5'h00, 5'h08, 16'hFC00, 16'h5400});
        send(32'hFFFFFFFF, 32'd0, 4'b0111, 1'b0, 1'b0, {5'h00, 5'h08, 16'h0000, 16'h7E00});
        send(32'hFFFFFFFF, 32'd512, 4'b0111, 1'b0, 1'b1, {5'h00, 5'h08, 16'h5000, 16'h7DFF});
        send(32'd1000, 32'hFFFFFFFF, 4'b0111, 1'b1, 1'b0, {5'h00, 5'h00, 16'hBE00, 16'h51E8});
        send(32'd1000, 32'hFFFFFFFF, 4'b0011, 1'b1, 1'b0, 42'd0);
        drain();
    endtask

    task automatic test_latency();
        int n;
        rdy_mode = 0;
        send(32'd7, 32'd3, 4'b0111, 1'b0, 1'b0, exp2(32'd7, 32'd3, 4'b0111, 1'b0, 1'b0));
        in_valid = 1'b0;
        for (n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
        end
        total++;
        if (n != 2) begin
            bad++;
            $display("FAIL latency: got %0d cycles want 2", n);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int s0;
        logic [31:0] a0, a1;
        logic [3:0]  e;
        logic        sm, rtz;
        rdy_mode = 0;
        s0 = stalls_seen;
        for (int i = 0; i < 6; i++) begin
            a0 = rnd_val();
            a1 = rnd_val();
            e = 4'b0111;
            sm = 1'($urandom);
            rtz = 1'($urandom);
            send(a0, a1, e, sm, rtz, exp2(a0, a1, e, sm, rtz));
        end
        in_valid = 1'b0;
        total++;
        if (stalls_seen != s0) begin
            bad++;
            $display("FAIL back_to_back_in_ready: got %0d stall cycles want 0", stalls_seen - s0);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int s0;
        logic [31:0] a0, a1;
        logic [3:0]  e;
        logic        sm, rtz;
        rdy_mode = 2;
        s0 = stalls_seen;
        for (int i = 0; i < 8; i++) begin
            a0 = rnd_val();
            a1 = rnd_val();
            e = ($urandom_range(0, 3) == 0) ? 4'b0011 : 4'b0111;
            sm = 1'($urandom);
            rtz = 1'($urandom);
            send(a0, a1, e, sm, rtz, exp2(a0, a1, e, sm, rtz));
        end
        drain();
        total++;
        if (stalls_seen == s0) begin
            bad++;
            $display("FAIL backpressure_stall: got 0 in_ready-low cycles want >0");
        end
        rdy_mode = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midflight();
        int seen;
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        send(32'd1000, 32'd5, 4'b0111, 1'b0, 1'b0, exp2(32'd1000, 32'd5, 4'b0111, 1'b0, 1'b0));
        send(32'd9, 32'd77, 4'b0111, 1'b0, 1'b0, exp2(32'd9, 32'd77, 4'b0111, 1'b0, 1'b0));
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        total += 4;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_out_valid: got %b want 0", out_valid); end
        if (float_out !== 32'h0) begin bad++; $display("FAIL midreset_float: got %h want 0", float_out); end
        if (exceptions !== 10'h0) begin bad++; $display("FAIL midreset_exc: got %h want 0", exceptions); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
        rdy_mode = 0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL midreset_stale: got %0d outputs want 0", seen);
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [63:0] data;
        logic        sm;
        logic        rtz;
        logic [15:0] f;
        logic [4:0]  e;
    } wvec_t;

    task automatic test_wide();
        wvec_t v[7];
        int    n;
        v[0] = '{64'h0000_0100_0000_0000, 1'b0, 1'b0, 16'h7FFE, 5'h0C};
        v[1] = '{64'hFFFF_FF00_0000_0000, 1'b1, 1'b0, 16'hFFFE, 5'h0C};
        v[2] = '{64'h0000_0001_0000_0000, 1'b0, 1'b0, 16'h7E00, 5'h00};
        v[3] = '{64'h0000_0001_FF80_0000, 1'b0, 1'b0, 16'h7FFE, 5'h0C};
        v[4] = '{64'h0000_0001_FFFF_FFFF, 1'b0, 1'b0, 16'h7FFE, 5'h0C};
        v[5] = '{64'h0000_0001_FFFF_FFFF, 1'b0, 1'b1, 16'h7FFE, 5'h0C};
        v[6] = '{64'd1000, 1'b1, 1'b0, 16'h51E8, 5'h00};
        for (int i = 0; i < 7; i++) begin
            w_in_valid = 1'b1;
            w_in = v[i].data;
            w_sm = v[i].sm;
            w_rnd = v[i].rtz;
            @(posedge clk);
            #1;
            w_in_valid = 1'b0;
            for (n = 0; n < 10; n++) begin
                @(negedge clk);
                if (w_out_valid === 1'b1) break;
            end
            total++;
            if (n == 10 || w_float !== v[i].f || w_exc !== v[i].e) begin
                bad++;
                $display("FAIL wide_%0d: got v=%b f=%h e=%h want v=1 f=%h e=%h",
                         i, w_out_valid, w_float, w_exc, v[i].f, v[i].e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_int = '0;
        ena = 4'b0111;
        signed_mode = 1'b0;
        rnd_mode = 1'b0;
        out_ready = 1'b1;
        w_in_valid = 1'b0;
        w_in = '0;
        w_ena = 4'b0111;
        w_sm = 1'b0;
        w_rnd = 1'b0;
        w_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_values();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
